// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write/read/clear bus of register_file
interface register_file_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic             clr;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             busy;
  logic             wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr,
    input  rd_data_a, rd_data_b, busy, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr,
    output rd_data_a, rd_data_b, busy, wr_err
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - DEPTH x WIDTH register file, two registered read ports, sequential clear sweep
// Optional macro REGFILE_BYPASS_EN forwards same-edge writes (port or sweep) to the read ports.
module register_file #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic             clk,
  input logic             rst,
  register_file_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q_a;
  logic [WIDTH-1:0] rd_q_b;
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_b;
  logic             busy_q;
  logic             wr_err_q;
  logic             wr_ok;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < (AW+1)'(DEPTH);
  endfunction

  assign wr_ok = (state == IDLE) && bus.wr_en && in_range(bus.wr_addr);

  function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] v;
    v = '0;
    if (in_range(addr)) v = mem[addr];
`ifdef REGFILE_BYPASS_EN
    // Port write and sweep never coincide: writes are only accepted in IDLE.
    if (state == CLEAR && ptr == addr) v = RESET_VAL;
    if (wr_ok && bus.wr_addr == addr) v = bus.wr_data;
`endif
    return v;
  endfunction

  always_comb begin
    rd_next_a = read_word(bus.rd_addr_a);
    rd_next_b = read_word(bus.rd_addr_b);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      rd_q_a   <= '0;
      rd_q_b   <= '0;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
      ptr      <= '0;
      state    <= IDLE;
    end else begin
      rd_q_a   <= rd_next_a;
      rd_q_b   <= rd_next_b;
      wr_err_q <= bus.wr_en && !wr_ok;
      if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
      case (state)
        IDLE: begin
          if (bus.clr) begin
            state  <= CLEAR;
            busy_q <= 1'b1;
            ptr    <= '0;
          end
        end
        CLEAR: begin
          mem[ptr] <= RESET_VAL;
          if (ptr == AW'(DEPTH - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ptr    <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data_a = rd_q_a;
  assign bus.rd_data_b = rd_q_b;
  assign bus.busy      = busy_q;
  assign bus.wr_err    = wr_err_q;
endmodule
